seg_frame_rx: RTL

//  Receiver for the free-computer display link. The lab-status encoder shifts out
//  7-segment codes (free = 5 - active computers) as serial frames. This block

---
 rtl/seg_frame_rx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seg_frame_rx.sv
// Serial receiver for the free-computer display link: deserialises start/7-data/
// even-parity/stop frames, validates them and decodes the 7-segment pattern
// back to free/used computer counts.
module seg_frame_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int N_COMPS      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       frame_valid,
  output logic [2:0] free_cnt,
  output logic [2:0] used_cnt,
  output logic [6:0] seg_last,
  output logic       err,
  output logic [1:0] err_type,
  output logic       busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  state_t        state, state_nxt;
  logic          rx_m, rx_s;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [6:0]    shreg;
  logic          par_bit;
  logic          tick;
  logic          dec_ok;
  logic [2:0]    dec_val;

  // Two-flop synchroniser; idles high so reset must not look like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rxd;
      rx_s <= rx_m;
    end
  end

  // Mid-bit sample strobe: half a bit into the start bit, a full bit afterwards
  always_comb begin
    tick = 1'b0;
    if (state == START) tick = (baud == HALF_LAST);
    else                tick = (baud == BAUD_LAST);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (tick && bit_cnt == 3'd6) state_nxt = PARITY;
      PARITY:    if (tick) state_nxt = STOP;
      STOP:      if (tick) state_nxt = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Busy covers the whole frame, including a stuck-low line after a framing error
  always_comb begin
    busy = (state != IDLE);
  end

  // Segment pattern decode; anything outside the six digits is illegal
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 3'd0;
    case (shreg)
      7'b1111110: dec_val = 3'd0;
      7'b0110000: dec_val = 3'd1;
      7'b1101101: dec_val = 3'd2;
      7'b1111001: dec_val = 3'd3;
      7'b0110011: dec_val = 3'd4;
      7'b1011011: dec_val = 3'd5;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // Baud and bit counters plus the shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud    <= '0;
      bit_cnt <= 3'd0;
      shreg   <= 7'd0;
      par_bit <= 1'b0;
    end else begin
      if (state == IDLE || state == WAIT_IDLE || tick) baud <= '0;
      else                                             baud <= baud + 1'b1;
      if (state == IDLE) begin
        bit_cnt <= 3'd0;
      end else if (state == DATA && tick) begin
        shreg   <= {shreg[5:0], rx_s};
        bit_cnt <= (bit_cnt == 3'd6) ? 3'd0 : bit_cnt + 3'd1;
      end
      if (state == PARITY && tick) par_bit <= rx_s;
    end
  end

  // Frame resolution at the stop sample: framing beats parity beats illegal pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_type    <= 2'b00;
      free_cnt    <= 3'd5;
      used_cnt    <= 3'd0;
      seg_last    <= 7'b1011011;
    end else begin
      frame_valid <= 1'b0;
      err         <= 1'b0;
      if (state == STOP && tick) begin
        if (!rx_s) begin
          err      <= 1'b1;
          err_type <= 2'b01;
        end else if (^{shreg, par_bit}) begin
          err      <= 1'b1;
          err_type <= 2'b10;
        end else if (!dec_ok) begin
          err      <= 1'b1;
          err_type <= 2'b11;
        end else begin
          frame_valid <= 1'b1;
          free_cnt    <= dec_val;
          used_cnt    <= 3'(N_COMPS) - dec_val;
          seg_last    <= shreg;
        end
      end
    end
  end

endmodule
